// File: rtl/aes_decryption.sv
// Iterative AES-128 decryption core: expands all 11 round keys, then runs the
// inverse cipher one round per clock and pulses valid_flag with the plaintext.
package aes_dec_pkg;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0 as AES needs
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        logic [7:0] v;
        v = gf_inv(b);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] mul_9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul_b(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] mul_d(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul_e(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic logic [0:31] inv_mix_col(input logic [0:31] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[0+:8];
        a1 = c[8+:8];
        a2 = c[16+:8];
        a3 = c[24+:8];
        return {mul_e(a0) ^ mul_b(a1) ^ mul_d(a2) ^ mul_9(a3),
                mul_9(a0) ^ mul_e(a1) ^ mul_b(a2) ^ mul_d(a3),
                mul_d(a0) ^ mul_9(a1) ^ mul_e(a2) ^ mul_b(a3),
                mul_b(a0) ^ mul_d(a1) ^ mul_9(a2) ^ mul_e(a3)};
    endfunction

endpackage

module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    assign o_byte = aes_dec_pkg::sbox_fwd(i_byte);
endmodule

module aes_inv_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    assign o_byte = aes_dec_pkg::sbox_inv(i_byte);
endmodule

module aes_decryption
    import aes_dec_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [0:127] cipher_text,
    input  logic [0:127] key,
    output logic [0:127] dec_data,
    output logic         valid_flag,
    output logic         busy
);

    typedef enum logic [2:0] {IDLE, KEYEXP, ADDKEY, ROUND, FINAL} fsm_t;

    fsm_t         r_fsm;
    logic [3:0]   r_cnt;
    logic [0:127] r_ct;
    logic [0:127] r_state;
    logic [0:127] r_rk [0:10];

    logic [0:127] w_prev_rk;
    logic [0:127] w_cur_rk;
    logic [0:31]  w_rot;
    logic [0:31]  w_sub;
    logic [0:31]  w_temp;
    logic [0:31]  w_k0, w_k1, w_k2, w_k3;
    logic [0:127] w_isr;
    logic [0:127] w_isb;
    logic [0:127] w_ark;
    logic [0:127] w_imc;

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Key expansion: rk[cnt] derived from rk[cnt-1] (RotWord, SubWord, Rcon)
    assign w_prev_rk = r_rk[r_cnt - 4'd1];
    assign w_cur_rk  = r_rk[r_cnt];
    assign w_rot     = {w_prev_rk[104+:8], w_prev_rk[112+:8], w_prev_rk[120+:8], w_prev_rk[96+:8]};

    genvar gb;
    for (gb = 0; gb < 4; gb++) begin : g_ksub
        aes_sbox u_sbox (.i_byte(w_rot[8*gb +: 8]), .o_byte(w_sub[8*gb +: 8]));
    end

    assign w_temp = w_sub ^ {rcon(r_cnt), 24'h000000};
    assign w_k0   = w_prev_rk[0+:32]  ^ w_temp;
    assign w_k1   = w_prev_rk[32+:32] ^ w_k0;
    assign w_k2   = w_prev_rk[64+:32] ^ w_k1;
    assign w_k3   = w_prev_rk[96+:32] ^ w_k2;

    // Inverse round datapath: InvShiftRows moves row r right by r columns
    genvar gc, gr;
    for (gc = 0; gc < 4; gc++) begin : g_col
        for (gr = 0; gr < 4; gr++) begin : g_row
            assign w_isr[8*(4*gc+gr) +: 8] = r_state[8*(4*((gc - gr + 4) % 4) + gr) +: 8];
            aes_inv_sbox u_isbox (.i_byte(w_isr[8*(4*gc+gr) +: 8]), .o_byte(w_isb[8*(4*gc+gr) +: 8]));
        end
        assign w_imc[32*gc +: 32] = inv_mix_col(w_ark[32*gc +: 32]);
    end

    assign w_ark = w_isb ^ w_cur_rk;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fsm      <= IDLE;
            r_cnt      <= 4'd0;
            r_ct       <= '0;
            r_state    <= '0;
            dec_data   <= '0;
            valid_flag <= 1'b0;
            busy       <= 1'b0;
            for (int i = 0; i < 11; i++) r_rk[i] <= '0;
        end else begin
            valid_flag <= 1'b0;
            case (r_fsm)
                IDLE: begin
                    if (start) begin
                        r_ct     <= cipher_text;
                        r_rk[0]  <= key;
                        r_cnt    <= 4'd1;
                        busy     <= 1'b1;
                        r_fsm    <= KEYEXP;
                    end
                end
                KEYEXP: begin
                    r_rk[r_cnt] <= {w_k0, w_k1, w_k2, w_k3};
                    if (r_cnt == 4'd10) r_fsm <= ADDKEY;
                    else                r_cnt <= r_cnt + 4'd1;
                end
                ADDKEY: begin
                    r_state <= r_ct ^ r_rk[10];
                    r_cnt   <= 4'd9;
                    r_fsm   <= ROUND;
                end
                ROUND: begin
                    r_state <= w_imc;
                    r_cnt   <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_fsm <= FINAL;
                end
                FINAL: begin
                    dec_data   <= w_isb ^ r_rk[0];
                    valid_flag <= 1'b1;
                    busy       <= 1'b0;
                    r_cnt      <= 4'd0;
                    r_fsm      <= IDLE;
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decryption.sv
// Directed bench for aes_decryption: FIPS-197 vectors, back-to-back, busy-ignore,
// reset abort and a loopback against an independent encryption model.
module tb_aes_decryption;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [0:127] cipher_text;
    logic [0:127] key;
    logic [0:127] dec_data;
    logic         valid_flag;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_valid  = 0;

    logic [0:127] exp_q[$];
    int           exp_cyc_q[$];
    logic [7:0]   sb [0:255];

    localparam logic [0:127] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] RK1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [0:127] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] RK2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    aes_decryption dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .cipher_text (cipher_text),
        .key         (key),
        .dec_data    (dec_data),
        .valid_flag  (valid_flag),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk_blk(input string tag, input logic [0:127] got, input logic [0:127] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        n_checks++;
        assert (got == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference encryption model, written independently of the decryption RTL
    function automatic logic [7:0] tb_xt(input logic [7:0] b);
        return b[7] ? ((b << 1) ^ 8'h1b) : (b << 1);
    endfunction

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        while (y != 8'h00) begin
            if (y[0]) p = p ^ x;
            x = tb_xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] tb_rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [0:127] aes_enc(input logic [0:127] k, input logic [0:127] p);
        logic [0:127] rk [0:10];
        logic [0:127] s, t;
        logic [0:31]  w;
        logic [7:0]   rc, a0, a1, a2, a3;
        rk[0] = k;
        rc    = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            w = rk[r-1][96+:32];
            w = {sb[w[8+:8]], sb[w[16+:8]], sb[w[24+:8]], sb[w[0+:8]]} ^ {rc, 24'h000000};
            rk[r][0+:32] = rk[r-1][0+:32] ^ w;
            for (int j = 1; j < 4; j++) rk[r][32*j+:32] = rk[r-1][32*j+:32] ^ rk[r][32*(j-1)+:32];
            rc = tb_xt(rc);
        end
        s = p ^ rk[0];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[8*i+:8] = sb[s[8*i+:8]];
            t = s;
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[8*(4*c+row)+:8] = t[8*(4*((c + row) % 4) + row)+:8];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[32*c+:8];
                    a1 = s[32*c+8+:8];
                    a2 = s[32*c+16+:8];
                    a3 = s[32*c+24+:8];
                    s[32*c+:8]    = tb_xt(a0) ^ tb_xt(a1) ^ a1 ^ a2 ^ a3;
                    s[32*c+8+:8]  = a0 ^ tb_xt(a1) ^ tb_xt(a2) ^ a2 ^ a3;
                    s[32*c+16+:8] = a0 ^ a1 ^ tb_xt(a2) ^ tb_xt(a3) ^ a3;
                    s[32*c+24+:8] = tb_xt(a0) ^ a0 ^ a1 ^ a2 ^ tb_xt(a3);
                end
            end
            s = s ^ rk[r];
        end
        return s;
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drive one start pulse; the result is due 22 sampled cycles from now
    task automatic drive_start(input logic [0:127] k, input logic [0:127] ct,
                               input bit expect_result, input logic [0:127] pt);
        start       = 1'b1;
        key         = k;
        cipher_text = ct;
        if (expect_result) begin
            exp_q.push_back(pt);
            exp_cyc_q.push_back(cyc + 22);
        end
        @(posedge clock);
        #1;
        start       = 1'b0;
        key         = rand128();
        cipher_text = rand128();
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clock);
            k++;
        end
        if (exp_q.size() != 0) begin
            chk_int("completion_timeout", exp_q.size(), 0);
            exp_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    // Scoreboard: every valid_flag cycle must match the oldest outstanding request
    always @(negedge clock) begin
        if (!reset && valid_flag) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                chk_int("spurious_valid", exp_q.size(), 1);
            end else begin
                logic [0:127] e;
                int           ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                chk_blk("dec_data", dec_data, e);
                chk_int("valid_latency", cyc, ec);
                chk_bit("busy_at_valid", busy, 1'b0);
            end
        end
    end

    initial begin
        int k;
        int v0;
        logic [0:127] rk_, rp, rc_;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, xb;
            xb  = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (tb_mul(xb, 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ tb_rotl(inv, 1) ^ tb_rotl(inv, 2) ^ tb_rotl(inv, 3) ^ tb_rotl(inv, 4) ^ 8'h63;
        end

        reset       = 1'b1;
        start       = 1'b0;
        key         = '0;
        cipher_text = '0;
        repeat (3) @(posedge clock);
        #1;
        chk_blk("reset_dec_data", dec_data, '0);
        chk_bit("reset_valid", valid_flag, 1'b0);
        chk_bit("reset_busy", busy, 1'b0);
        chk_blk("reset_rk10", dut.r_rk[10], '0);
        chk_int("reset_cnt", int'(dut.r_cnt), 0);

        // reset and start together: start must be dropped
        start = 1'b1;
        key   = K1;
        cipher_text = CT1;
        @(posedge clock);
        #1;
        chk_bit("reset_wins_busy", busy, 1'b0);
        start = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk_bit("start_dropped_busy", busy, 1'b0);

        // FIPS-197 C.1
        drive_start(K1, CT1, 1'b1, PT1);
        chk_bit("busy_after_start", busy, 1'b1);
        wait_done(40);
        chk_blk("c1_rk10", dut.r_rk[10], RK1);
        @(posedge clock);
        #1;

        // back-to-back: C.1 then Appendix B started in the valid_flag cycle
        drive_start(K1, CT1, 1'b1, PT1);
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!valid_flag && k < 40);
        if (!valid_flag) chk_bit("b2b_first_valid", valid_flag, 1'b1);
        drive_start(K2, CT2, 1'b1, PT2);
        wait_done(40);
        chk_blk("appb_rk10", dut.r_rk[10], RK2);
        @(posedge clock);
        #1;

        // start with junk while busy must be ignored
        v0 = n_valid;
        drive_start(K1, CT1, 1'b1, PT1);
        repeat (4) @(posedge clock);
        #1;
        start       = 1'b1;
        key         = rand128();
        cipher_text = rand128();
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(40);
        repeat (30) @(negedge clock);
        chk_int("busy_ignore_single_valid", n_valid - v0, 1);
        @(posedge clock);
        #1;

        // reset in the middle of an operation
        v0 = n_valid;
        drive_start(K1, CT1, 1'b0, PT1);
        repeat (11) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk_blk("abort_dec_data", dec_data, '0);
        chk_bit("abort_valid", valid_flag, 1'b0);
        chk_bit("abort_busy", busy, 1'b0);
        chk_blk("abort_rk10", dut.r_rk[10], '0);
        reset = 1'b0;
        repeat (30) @(negedge clock);
        chk_int("abort_no_valid", n_valid - v0, 0);
        drive_start(K1, CT1, 1'b1, PT1);
        wait_done(40);

        // loopback against the encryption model
        for (int i = 0; i < 200; i++) begin
            rk_ = rand128();
            rp  = rand128();
            rc_ = aes_enc(rk_, rp);
            drive_start(rk_, rc_, 1'b1, rp);
            wait_done(40);
        end

        repeat (5) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_decryption.md
# aes_decryption

Iterative AES-128 decryption core, the inverse counterpart of the encryption top. It accepts a 128-bit ciphertext and cipher key on a start pulse and expands and stores all 11 round keys internally. It then runs the inverse cipher one round per clock and returns the plaintext with a one-cycle valid pulse. It pairs with the encryption core in the same design so that a link endpoint can recover data encrypted by its peer.

## Interface
- No parameters; fixed to AES-128 (Nk=4, Nr=10).
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
- start  input  1  request pulse; sampled only in IDLE.
- cipher_text  input  [0:127]  ciphertext; byte 0 = bits 0:7, column-major as in FIPS-197.
- key  input  [0:127]  cipher key, same byte order.
- dec_data  output  [0:127]  recovered plaintext; holds until the next completion.
- valid_flag  output  1  one-cycle pulse, coincident with new dec_data.
- busy  output  1  high while an operation is in progress.

## Operation
- FSM states: IDLE, KEYEXP, ADDKEY, ROUND, FINAL.
- IDLE, start=1:
  - latch cipher_text and key;
  - rk[0] <= key; cnt <= 1;
  - go to KEYEXP.
- KEYEXP: each cycle computes rk[cnt] from rk[cnt-1] using standard expansion:
  - RotWord, forward SubWord, Rcon[cnt] = 01,02,04,08,10,20,40,80,1b,36.
  - At cnt=10, go to ADDKEY.
- Round keys live in an 11x128 register bank. Forward S-box comes from the existing Sbox module; inverse S-box from a sibling combinational inv_sbox module (16 instances).
- ADDKEY:
  - state <= ct_latched ^ rk[10]; cnt <= 9;
  - go to ROUND.
- ROUND (cnt 9 down to 1):
  - state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[cnt]));
  - at cnt=1, go to FINAL.
- FINAL:
  - dec_data <= InvSubBytes(InvShiftRows(state)) ^ rk[0];
  - valid_flag <= 1;
  - go to IDLE.
- InvMixColumns: each column multiplied by matrix {0e,0b,0d,09} in GF(2^8), reduction polynomial 0x11b, built from xtime chains.
- start outside IDLE is ignored; no queueing.
- Inputs need only be stable on the start edge; later changes have no effect.

## Timing
- Reset values:
  - FSM = IDLE; cnt = 0;
  - dec_data = 0; valid_flag = 0; busy = 0;
  - state and round-key bank = 0.
- Latency: start sampled at edge E0; rk[1..10] written at E1..E10; ADDKEY at E11; middle rounds at E12..E20; FINAL at E21.
- dec_data and valid_flag are updated at E21 and visible in the cycle after, i.e. 21 cycles after start is sampled.
- busy goes high after E0 and low after E21, in the same cycle that valid_flag is high.
- Throughput: one block per 22 cycles at best. start in the valid_flag cycle is accepted, since the FSM is in IDLE.
- valid_flag deasserts after exactly one cycle regardless of start.
- reset mid-operation:
  - abort immediately; all outputs take their reset values on that edge;
  - no valid_flag is produced for the aborted block.
- reset and start in the same cycle: reset wins and start is dropped.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, cipher_text 69c4e0d86a7b0430d8cdb78070b4c55a, start pulse.
  - Required: valid_flag 21 cycles later, dec_data 00112233445566778899aabbccddeeff, internal rk[10] = 13111d7fe3944a17f307a78b4d2b30c5.
- FIPS-197 Appendix B: key 2b7e151628aed2a6abf7158809cf4f3c, cipher_text 3925841d02dc09fbdc118597196a0b32.
  - Required: dec_data 3243f6a8885a308d313198a2e0370734, rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Back-to-back: run C.1, then start Appendix B in the valid_flag cycle.
  - Required: both results correct; second valid_flag exactly 22 cycles after the first.
- Busy ignore: pulse start with junk inputs at cycle 5 of a C.1 run.
  - Required: result unaffected; exactly one valid_flag.
- Reset mid-op: assert reset at cycle 12 of C.1, then restart C.1.
  - Required: outputs zero on the reset edge; no valid_flag for the aborted run; restarted run correct.
- Loopback: encrypt 200 random key/plaintext pairs with the existing encryption core, feed each result here with the same key.
  - Required: dec_data equals the original plaintext every time.
